mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous 32-bit RAM between the CPU fetch port
// (read-only) and the load/store port. Data wins contention by default; a
// starvation counter hands the RAM to fetch after STARVE_LIMIT consecutive
// denied fetch cycles, so fetch is never locked out. Read data comes back one
// cycle after the grant, steered to the master that owned the read.
//
// Parameters
//   MEM_AW        RAM word-address width (depth = 2**MEM_AW words)
//   STARVE_LIMIT  denied fetch cycles before fetch beats data (>= 1)
//
// Ports
//   clk, rst                      clock, async active-high reset
//   if_req_i / if_addr_i          fetch request + byte address
//   if_gnt_o                      fetch accepted (combinational)
//   if_rvalid_o / if_rdata_o      fetch read response (1 cycle after grant)
//   d_req_i, d_we_i, d_be_i,
//   d_addr_i, d_wdata_i           load/store request
//   d_gnt_o                       data accepted (combinational)
//   d_rvalid_o / d_rdata_o        data read response (reads only)
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o       RAM command
//   mem_rdata_i                   RAM read data, one cycle after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_AW       = 12,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,

    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Who owns the read data arriving from the RAM next cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_e;

    rsp_e          rsp_owner, rsp_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          fetch_wins;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:MEM_AW+2], if_addr_i[1:0],
                                d_addr_i[31:MEM_AW+2],  d_addr_i[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_owner  <= RSP_NONE;
            starve_cnt <= '0;
        end else begin
            rsp_owner  <= rsp_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Grant, RAM command and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        mem_we_o    = '0;
        mem_wdata_o = d_wdata_i;
        mem_addr_o  = d_addr_i[MEM_AW+1:2];
        rsp_nxt     = RSP_NONE;
        starve_nxt  = '0;

        // Fetch wins when alone, or when it has been starved long enough.
        fetch_wins = if_req_i && (!d_req_i || (starve_cnt == LIMIT));

        // Grants are gated by reset so nothing reaches the RAM while held.
        if (!rst) begin
            if_gnt_o = fetch_wins;
            d_gnt_o  = d_req_i && !fetch_wins;
        end

        mem_en_o = if_gnt_o || d_gnt_o;

        if (if_gnt_o) begin
            mem_addr_o = if_addr_i[MEM_AW+1:2];
            rsp_nxt    = RSP_IF;
        end else if (d_gnt_o) begin
            if (d_we_i) begin
                mem_we_o = d_be_i;
            end else begin
                rsp_nxt = RSP_D;
            end
        end

        // Counts only consecutive denied fetch cycles; saturates at LIMIT.
        if (if_req_i && !if_gnt_o) begin
            starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Read response steering
    // -------------------------------------------------------------------------
    assign if_rvalid_o = (rsp_owner == RSP_IF);
    assign d_rvalid_o  = (rsp_owner == RSP_D);
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM attached.
module tb_mem_arbiter;

    localparam int MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata;
    logic              d_gnt, d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(MEM_AW), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Behavioural RAM: byte-enabled write, one-cycle read latency.
    logic [31:0] ram [0:(1<<MEM_AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic idle_inputs();
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF;
        #1;
        vectors++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%h rv=%b%b want all 0",
                     if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid);
        end
        vectors++;
        if (dut.starve_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
        end
        @(negedge clk); @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_data_write_read();
        @(negedge clk);
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
        #1;
        vectors++;
        if ({d_gnt, if_gnt, mem_en, mem_we} !== 7'b1011111 || mem_addr !== 12'd8 ||
            mem_wdata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL wr_full: got gnt=%b%b en=%b we=%h addr=%0d wd=%h want 1 0 1 f 8 aabbccdd",
                     d_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        d_be = 4'b0011; d_wdata = 32'h11223344;
        #1;
        vectors++;
        if (mem_we !== 4'b0011 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_partial: got we=%b rv=%b want 0011 0", mem_we, d_rvalid);
        end
        @(negedge clk);
        d_be = 4'b0000; d_wdata = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (d_gnt !== 1'b1 || mem_we !== 4'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_be0: got gnt=%b we=%b rv=%b want 1 0000 0", d_gnt, mem_we, d_rvalid);
        end
        @(negedge clk);
        d_we = 0; d_be = 4'hF;
        #1;
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 4'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue: got en=%b we=%b rv=%b want 1 0000 0", mem_en, mem_we, d_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hAABB3344 || if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got rv=%b data=%h ifrv=%b en=%b want 1 aabb3344 0 0",
                     d_rvalid, d_rdata, if_rvalid, mem_en);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse: got rv=%b want 0", d_rvalid);
        end
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h14; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        if_req = 1; if_addr = 32'h14;
        #1;
        vectors++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 12'd5 || mem_we !== 4'b0) begin
            errors++;
            $display("FAIL fetch_gnt: got gnt=%b%b addr=%0d we=%b want 1 0 5 0000",
                     if_gnt, d_gnt, mem_addr, mem_we);
        end
        @(negedge clk);
        if_addr = 32'hFFFF_C017;   // upper and low bits must be ignored
        #1;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0 || mem_addr !== 12'd5) begin
            errors++;
            $display("FAIL fetch_data: got rv=%b data=%h drv=%b addr=%0d want 1 deadbeef 0 5",
                     if_rvalid, if_rdata, d_rvalid, mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_hi_addr: got rv=%b data=%h want 1 deadbeef", if_rvalid, if_rdata);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: got rv=%b%b want 00", if_rvalid, d_rvalid);
        end
    endtask

    task automatic test_contention();
        int n_if = 0;
        logic prev_if = 1'b0, prev_any = 1'b0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h14;
        d_req = 1; d_we = 0; d_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            #1;
            vectors++;
            if (if_gnt !== (c % 4 == 3) || d_gnt !== (c % 4 != 3) || dut.starve_cnt !== 2'(c % 4)) begin
                errors++;
                $display("FAIL contend_c%0d: got gnt=%b%b starve=%0d want %b%b %0d", c,
                         if_gnt, d_gnt, dut.starve_cnt, (c % 4 == 3), (c % 4 != 3), c % 4);
            end
            if (if_gnt === 1'b1) n_if++;
            vectors++;
            if (if_rvalid !== (prev_any && prev_if) || d_rvalid !== (prev_any && !prev_if) ||
                (prev_any && mem_rdata !== (prev_if ? 32'hDEADBEEF : 32'hAABB3344))) begin
                errors++;
                $display("FAIL contend_rsp_c%0d: got rv=%b%b data=%h", c, if_rvalid, d_rvalid, mem_rdata);
            end
            prev_any = 1'b1;
            prev_if  = (c % 4 == 3);
            @(negedge clk);
        end
        idle_inputs();
        vectors++;
        if (n_if != 3) begin
            errors++;
            $display("FAIL contend_count: got %0d fetch grants want 3", n_if);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if_req = 1; if_addr = 32'h14;
        #1;
        vectors++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_if_gnt: got %b%b want 10", if_gnt, d_gnt);
        end
        @(negedge clk);
        if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h20;
        #1;
        vectors++;
        if (d_gnt !== 1'b1 || if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_if_rsp: got dgnt=%b rv=%b%b data=%h want 1 10 deadbeef",
                     d_gnt, if_rvalid, d_rvalid, if_rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'hAABB3344) begin
            errors++;
            $display("FAIL b2b_d_rsp: got rv=%b%b data=%h want 01 aabb3344", if_rvalid, d_rvalid, d_rdata);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got rv=%b%b want 00", if_rvalid, d_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h20;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt: got %b want 1", d_gnt);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 7'b0) begin
            errors++;
            $display("FAIL rst_mid_force: got gnt=%b%b en=%b we=%b want 0", if_gnt, d_gnt, mem_en, mem_we);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en} !== 5'b0 || dut.starve_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_hold: got rv=%b%b gnt=%b%b en=%b want 0",
                     if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en);
        end
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got rv=%b%b want 00", if_rvalid, d_rvalid);
        end
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 9'b0) begin
                errors++;
                $display("FAIL idle_c%0d: got en=%b we=%b gnt=%b%b rv=%b%b want 0", c,
                         mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_write_read();
        test_lone_fetch();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
